carry_accum: RTL and testbench
==============================

CARRY_ACCUM -- requirements
Module: carry_accum

Interface
REQ-001 SHALL have parameter: WIDTH, 8, accumulator width in bits (legal 2..64).
REQ-002 SHALL have parameter: INIT, {WIDTH{1'b0}}, value loaded into Q on reset.
REQ-003 SHALL have port: C  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port: R  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port: CE  input  1  clock enable for accumulate operation.
REQ-006 SHALL have port: LOAD  input  1  synchronous load of D into Q.
REQ-007 SHALL have port: D  input  WIDTH  load value.
REQ-008 SHALL have port: B  input  WIDTH  operand added to or subtracted from Q.
REQ-009 SHALL have port: ADDSUB  input  1  1 = add, 0 = subtract.
REQ-010 SHALL have port: CI  input  1  carry-in to LSB of the chain.
REQ-011 SHALL have port: Q  output  WIDTH  registered accumulator value.
REQ-012 SHALL have port: CO  output  1  registered carry-out of MSB, feeding the downstream carry-mux stage.
REQ-013 SHALL have port: OVF  output  1  sticky signed-overflow flag, registered.
REQ-014 SHALL have port: TC  output  1  terminal count, combinational from Q and ADDSUB.

Function
REQ-015 Priority per edge SHALL be R > LOAD > CE > hold.
REQ-016 Add (ADDSUB=1, CE=1) SHALL compute {CO,Q} <= Q + B + CI, full WIDTH+1-bit result.
REQ-017 Subtract (ADDSUB=0, CE=1) SHALL compute {CO,Q} <= Q + ~B + CI, carry-chain style; CO=1 means no borrow; CI=1 gives true Q-B.
REQ-018 Latency SHALL be one cycle: result visible on Q/CO after the edge where CE=1.
REQ-019 OVF SHALL set when an accumulate operation produces two's-complement signed overflow (operand MSBs equal, result MSB differs, using ~B for subtract).
REQ-020 OVF SHALL remain set through holds and further operations until R or LOAD.
REQ-021 LOAD SHALL set Q <= D, CO <= 0, OVF <= 0, regardless of CE.
REQ-022 CE=0 with LOAD=0, R=0 SHALL hold Q, CO, OVF unchanged.
REQ-023 TC SHALL be 1 when ADDSUB=1 and Q all ones, or ADDSUB=0 and Q all zeros; else 0.
REQ-024 Wrap-around (no saturation) SHALL be modulo 2^WIDTH; CO reports the carry/no-borrow.
REQ-025 No X SHALL propagate to Q from CE/LOAD when R=1.

Reset
REQ-026 On R=1 at an edge, Q SHALL become INIT, CO 0, OVF 0, overriding LOAD and CE.
REQ-027 R asserted mid-sequence SHALL discard the in-progress operation; the next CE=1 after R deasserts accumulates from INIT.
REQ-028 Before the first edge with R=1, outputs SHALL be INIT/0/0 (register initial values).

Configuration
REQ-029 Macro XIL_CARRY_ACCUM_SAT_EN SHALL, when defined, enable unsigned saturation: add with carry-out SHALL give Q all ones, subtract with borrow SHALL give Q all zeros; CO and OVF still report the raw result.
REQ-030 Without XIL_CARRY_ACCUM_SAT_EN, Q SHALL wrap per REQ-024 and no saturation logic SHALL be present.

Verification (WIDTH=8, INIT=8'h00)
REQ-031 R=1 one edge, LOAD=1 D=8'hAA same edge -> Q=8'h00, CO=0, OVF=0.
REQ-032 LOAD D=8'hFE; then CE=1 ADDSUB=1 B=8'h01 CI=1 -> Q=8'h00 CO=1 (SAT_EN: Q=8'hFF CO=1).
REQ-033 LOAD D=8'h10; CE=1 ADDSUB=0 B=8'h01 CI=1 -> Q=8'h0F CO=1; LOAD 8'h00 then same sub -> Q=8'hFF CO=0 (SAT_EN: Q=8'h00).
REQ-034 LOAD D=8'h7F; CE=1 ADDSUB=1 B=8'h01 CI=0 -> Q=8'h80 OVF=1; OVF stays 1 over 3 CE=0 cycles and a further add of 8'h01; LOAD clears it.
REQ-035 LOAD=1 and CE=1 same edge D=8'h33 B=8'h05 -> Q=8'h33; CE=0 for 4 edges -> Q stays 8'h33.
REQ-036 Q=8'hFF ADDSUB=1 -> TC=1; switch ADDSUB=0 same cycle -> TC=0; Q=8'h00 ADDSUB=0 -> TC=1.

Source files
------------

// File: rtl/carry_accum.sv
// Registered add/sub accumulator with carry-out and sticky signed overflow.
// Define XIL_CARRY_ACCUM_SAT_EN to make Q saturate instead of wrapping.
module carry_accum #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] INIT = {WIDTH{1'b0}}
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] B,
  input  logic             ADDSUB,
  input  logic             CI,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             OVF,
  output logic             TC
);

  logic [WIDTH-1:0] acc = INIT;
  logic             co_r = 1'b0;
  logic             ovf_r = 1'b0;

  logic [WIDTH-1:0] opb;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] nxt;
  logic             ovf_now;

  // Subtract reuses the adder with the operand inverted.
  always_comb begin
    opb = ADDSUB ? B : ~B;
    sum = {1'b0, acc} + {1'b0, opb}
        + {{WIDTH{1'b0}}, CI};
    ovf_now = (acc[WIDTH-1] == opb[WIDTH-1])
            && (sum[WIDTH-1] != acc[WIDTH-1]);
    nxt = sum[WIDTH-1:0];
`ifdef XIL_CARRY_ACCUM_SAT_EN
    if (ADDSUB && sum[WIDTH])
      nxt = {WIDTH{1'b1}};
    else if (!ADDSUB && !sum[WIDTH])
      nxt = {WIDTH{1'b0}};
`else
    nxt = sum[WIDTH-1:0];
`endif
  end

  always_ff @(posedge C) begin
    if (R) begin
      acc   <= INIT;
      co_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else if (LOAD) begin
      acc   <= D;
      co_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else if (CE) begin
      acc   <= nxt;
      co_r  <= sum[WIDTH];
      ovf_r <= ovf_r | ovf_now;
    end
  end

  assign Q   = acc;
  assign CO  = co_r;
  assign OVF = ovf_r;
  assign TC  = ADDSUB ? (&acc) : ~(|acc);

endmodule

// File: tb/tb_carry_accum.sv
// Scoreboarded random + directed bench for carry_accum (WIDTH=8).
// Reference model uses plain integer arithmetic.
module tb_carry_accum;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         r = 1'b0;
  logic         ce = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] b = '0;
  logic         addsub = 1'b1;
  logic         ci = 1'b0;
  logic [W-1:0] q;
  logic         co;
  logic         ovf;
  logic         tc;

  carry_accum #(.WIDTH(W), .INIT(8'h00)) dut (
    .C(clk), .R(r), .CE(ce), .LOAD(load),
    .D(d), .B(b), .ADDSUB(addsub), .CI(ci),
    .Q(q), .CO(co), .OVF(ovf), .TC(tc)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int co;
    int ovf;
  } exp_t;

  exp_t sbq[$];
  int   mq = 0;
  int   mco = 0;
  int   movf = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name,
                     input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Model: integer add with signed-range overflow test.
  task automatic model(input int rr, input int ll,
                       input int cc, input int dd,
                       input int bb, input int as,
                       input int cin);
    int opb, full, sa, sb, ss;
    if (rr != 0) begin
      mq = 0; mco = 0; movf = 0;
    end else if (ll != 0) begin
      mq = dd; mco = 0; movf = 0;
    end else if (cc != 0) begin
      opb  = as ? bb : (255 - bb);
      full = mq + opb + cin;
      sa   = (mq  > 127) ? mq  - 256 : mq;
      sb   = (opb > 127) ? opb - 256 : opb;
      ss   = sa + sb + cin;
      mco  = full / 256;
      if (ss > 127 || ss < -128) movf = 1;
      mq   = full % 256;
`ifdef XIL_CARRY_ACCUM_SAT_EN
      if (as != 0 && mco == 1) mq = 255;
      if (as == 0 && mco == 0) mq = 0;
`endif
    end
  endtask

  task automatic drive(input int rr, input int ll,
                       input int cc, input int dd,
                       input int bb, input int as,
                       input int cin);
    exp_t e;
    @(negedge clk);
    r = rr[0]; load = ll[0]; ce = cc[0];
    d = dd[W-1:0]; b = bb[W-1:0];
    addsub = as[0]; ci = cin[0];
    model(rr, ll, cc, dd, bb, as, cin);
    e.q = mq; e.co = mco; e.ovf = movf;
    sbq.push_back(e);
  endtask

  // Monitor: every edge whose stimulus was queued is checked.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      chk("q", q, e.q);
      chk("co", co, e.co);
      chk("ovf", ovf, e.ovf);
      chk("tc", tc, addsub ? (e.q == 255)
                           : (e.q == 0));
    end
  end

  task automatic tc_now(input string name,
                        input int as, input int exp);
    addsub = as[0];
    #1;
    chk(name, tc, exp);
  endtask

  initial begin
    #1;
    chk("init_q", q, 0);
    chk("init_co", co, 0);
    chk("init_ovf", ovf, 0);

    // reset beats load
    drive(1, 1, 1, 8'hAA, 8'h11, 1, 1);
    // add wraps to zero with carry
    drive(0, 1, 0, 8'hFE, 0, 1, 0);
    drive(0, 0, 1, 0, 8'h01, 1, 1);
    // true subtract without and with borrow
    drive(0, 1, 0, 8'h10, 0, 1, 0);
    drive(0, 0, 1, 0, 8'h01, 0, 1);
    drive(0, 1, 0, 8'h00, 0, 1, 0);
    drive(0, 0, 1, 0, 8'h01, 0, 1);
    // sticky overflow
    drive(0, 1, 0, 8'h7F, 0, 1, 0);
    drive(0, 0, 1, 0, 8'h01, 1, 0);
    repeat (3) drive(0, 0, 0, 0, 8'h01, 1, 0);
    drive(0, 0, 1, 0, 8'h01, 1, 0);
    drive(0, 1, 0, 8'h05, 0, 1, 0);
    // load overrides CE, then hold
    drive(0, 1, 1, 8'h33, 8'h05, 1, 0);
    repeat (4) drive(0, 0, 0, 0, 8'h05, 1, 1);
    // terminal count tracks ADDSUB combinationally
    drive(0, 1, 0, 8'hFF, 0, 1, 0);
    @(negedge clk);
    ce = 0; load = 0; r = 0;
    tc_now("tc_ff_add", 1, 1);
    tc_now("tc_ff_sub", 0, 0);
    drive(0, 1, 0, 8'h00, 0, 0, 0);
    @(negedge clk);
    ce = 0; load = 0;
    tc_now("tc_00_sub", 0, 1);
    tc_now("tc_00_add", 1, 0);
    // reset mid-sequence, accumulate restarts from INIT
    drive(0, 1, 0, 8'h40, 0, 1, 0);
    drive(0, 0, 1, 0, 8'h03, 1, 0);
    drive(1, 0, 1, 0, 8'h03, 1, 0);
    drive(0, 0, 1, 0, 8'h03, 1, 0);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) == 0),
            ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) != 0),
            $urandom_range(0, 255),
            $urandom_range(0, 255),
            $urandom_range(0, 1),
            $urandom_range(0, 1));
    end

    repeat (3) @(negedge clk);
    chk("sb_drained", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
